// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   RV32I load/store unit. Each access is handled alone through a four-state
//   FSM (IDLE, RD, WR, RESP) against a single-ported word memory whose read
//   data is combinational from mem_address.
//     - Loads read the word in RD, then extract and extend the lane in RESP.
//     - Word stores write directly in WR.
//     - Byte and half stores read the word in RD, merge the lane in WR and
//       write it back.
//     - Illegal accesses go straight to RESP with resp_err set and never
//       touch memory.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_we           1 = store, 0 = load
//   req_funct3       RV32I width code (B, H, W, BU, HU)
//   req_addr         byte address
//   req_wdata        right-aligned store data
//   resp_valid       one-cycle completion pulse
//   resp_rdata       extended load data (0 for stores and errors)
//   resp_err         access rejected, qualified by resp_valid
//   mem_address      word-aligned memory address (0 outside RD/WR)
//   mem_write_data   merged word to memory (0 outside WR)
//   mem_we           memory write strobe (high only in WR)
//   mem_read_data    memory word at mem_address
//
// Configuration:
//   LSU_MISALIGN_TRAP_EN  When defined, a halfword access with addr[0]=1 or
//                         a word access with addr[1:0]!=0 is rejected with
//                         resp_err. When undefined, address bits below the
//                         access size are ignored.
//
// Every output is decoded from the state register and the latched request;
// no req_* input reaches a mem_* output combinationally.
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_we,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q, state_d;
  logic        err_q, err_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;

  logic        accept;
  logic        req_bad;
  logic        misalign;

  // -------------------------------------------------------------------------
  // Width-code legality: unsigned widths exist only for loads.
  // -------------------------------------------------------------------------
  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // -------------------------------------------------------------------------
  // Load lane extraction with explicit signed extension for B/H.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    logic [31:0]        res;
    byte_s = $signed(word[{lane, 3'b000} +: 8]);
    half_s = lane[1] ? $signed(word[31:16]) : $signed(word[15:0]);
    ext_s  = '0;
    case (f3)
      F3_B:    begin ext_s = 32'(byte_s); res = $unsigned(ext_s); end
      F3_H:    begin ext_s = 32'(half_s); res = $unsigned(ext_s); end
      F3_BU:   res = {24'd0, $unsigned(byte_s)};
      F3_HU:   res = {16'd0, $unsigned(half_s)};
      default: res = word;
    endcase
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Store lane merge into the word captured in RD. A word store ignores the
  // captured word entirely.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    case (f3)
      F3_B: res[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Both H and HU are halfword accesses; HU stores are already illegal.
  assign misalign = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept  = req_valid && (state_q == IDLE);
  assign req_bad = funct3_illegal(req_we, req_funct3) || misalign;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = req_bad;
          if (req_bad)                  state_d = RESP;
          else if (!req_we)             state_d = RD;
          else if (req_funct3 == F3_W)  state_d = WR;
          else                          state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers: reset drops any in-flight access immediately, which
  // also drops mem_we since it is decoded from state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Request latch and RD-cycle word capture. These hold data only and are
  // never observed outside the states that follow an accept.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
    if (state_q == RD) begin
      word_q <= mem_read_data;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from state
  // -------------------------------------------------------------------------
  assign req_ready      = (state_q == IDLE);
  assign mem_we         = (state_q == WR);
  assign mem_address    = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_write_data = (state_q == WR) ? store_merge(word_q, wdata_q, funct3_q, addr_q[1:0])
                                          : 32'd0;
  assign resp_valid     = (state_q == RESP);
  assign resp_err       = (state_q == RESP) && err_q;
  assign resp_rdata     = (state_q == RESP && !err_q && !we_q)
                          ? load_extract(word_q, funct3_q, addr_q[1:0]) : 32'd0;

endmodule
